// File: rtl/inc16_arbiter.sv
// inc16_arbiter: round-robin shared 16-bit incrementer with a registered, backpressured response port
module inc16_arbiter #(
  parameter int N = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req_valid,
  input  logic [16*N-1:0] req_data,
  output logic [N-1:0]    req_ready,
  output logic            rsp_valid,
  output logic [15:0]     rsp_data,
  output logic [ID_W-1:0] rsp_id,
  output logic            rsp_wrap,
  input  logic            rsp_ready
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_q, rr_d, g, sel, id_q;
  logic [15:0]     data_q, op;
  logic            wrap_q, can_accept, xfer;
  int              idx;
  // Descending scan so the lowest cyclic offset from rr_q wins
  always_comb begin
    g = '0;
    idx = 0;
    sel = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      idx = idx >= N ? idx - N : idx;
      sel = ID_W'(idx);
      if (req_valid[sel]) g = sel;
    end
  end
  assign can_accept = state_q == EMPTY || rsp_ready;
  assign xfer = !reset && can_accept && |req_valid;
  assign op = req_data[16*g +: 16];
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      rr_q <= '0;
      data_q <= '0;
      id_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      if (xfer) begin
        data_q <= op + 16'd1;
        id_q <= g;
        wrap_q <= &op;
      end
    end
  end
  always_comb begin
    state_d = xfer ? FULL : (rsp_ready ? EMPTY : state_q);
    rr_d = xfer ? (int'(g) == N - 1 ? '0 : g + ID_W'(1)) : rr_q;
  end
  always_comb begin
    req_ready = xfer ? N'(1) << g : '0;
    rsp_valid = state_q == FULL;
    rsp_data = data_q;
    rsp_id = id_q;
    rsp_wrap = wrap_q;
  end
endmodule

// File: tb/tb_inc16_arbiter.sv
// tb_inc16_arbiter: directed vectors checked against a per-cycle behavioural model plus literal expectations
module tb_inc16_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_wrap;
  logic        rsp_ready;

  int vectors = 0;
  int miscompares = 0;

  // model state: the response register contents and the round-robin pointer
  logic        m_v = 1'b0;
  logic [15:0] m_d = '0;
  int          m_id = 0;
  logic        m_w = 1'b0;
  int          m_rr = 0;

  inc16_arbiter #(.N(4), .ID_W(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_wrap(rsp_wrap), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [15:0] opnd(input logic [63:0] d, input int i);
    return d[16*i +: 16];
  endfunction

  always @(posedge clk) begin
    int gg;
    logic [15:0] o;
    gg = pick(req_valid, m_rr);
    if (reset) begin
      m_v <= 1'b0; m_d <= '0; m_id <= 0; m_w <= 1'b0; m_rr <= 0;
    end else if ((!m_v || rsp_ready) && gg >= 0) begin
      o = opnd(req_data, gg);
      m_v <= 1'b1; m_d <= o + 16'd1; m_id <= gg; m_w <= (o == 16'hFFFF); m_rr <= (gg + 1) % 4;
    end else if (rsp_ready) begin
      m_v <= 1'b0;
    end
  end

  always @(negedge clk) begin
    int gg;
    logic [3:0] er;
    gg = pick(req_valid, m_rr);
    er = (!reset && (!m_v || rsp_ready) && gg >= 0) ? 4'(1 << gg) : 4'b0;
    vectors++;
    if (req_ready !== er || rsp_valid !== m_v || rsp_data !== m_d ||
        rsp_id !== 2'(m_id) || rsp_wrap !== m_w) begin
      miscompares++;
      $display("FAIL model t=%0t: got rdy=%b v=%b d=%h id=%0d w=%b, want rdy=%b v=%b d=%h id=%0d w=%b",
               $time, req_ready, rsp_valid, rsp_data, rsp_id, rsp_wrap, er, m_v, m_d, m_id, m_w);
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic set(input logic r, input logic [3:0] v, input logic [15:0] d0, input logic [15:0] d1,
                     input logic [15:0] d2, input logic [15:0] d3, input logic rr);
    reset = r;
    req_valid = v;
    req_data = {d3, d2, d1, d0};
    rsp_ready = rr;
  endtask

  initial begin
    set(1, 4'b1111, 16'h1, 16'h2, 16'h3, 16'h4, 1);
    mid();
    chk("reset_ready", 16'(req_ready), 16'h0);
    step();
    step();
    set(0, 4'b0000, 0, 0, 0, 0, 1);
    mid();
    chk("rst_valid", 16'(rsp_valid), 16'h0);
    chk("rst_data", rsp_data, 16'h0000);
    chk("rst_id", 16'(rsp_id), 16'h0);
    chk("rst_wrap", 16'(rsp_wrap), 16'h0);
    step();
    set(0, 4'b0001, 16'h0005, 0, 0, 0, 1);
    mid();
    chk("single_ready", 16'(req_ready), 16'h0001);
    step();
    set(0, 4'b0000, 0, 0, 0, 0, 1);
    mid();
    chk("single_valid", 16'(rsp_valid), 16'h1);
    chk("single_data", rsp_data, 16'h0006);
    chk("single_id", 16'(rsp_id), 16'h0);
    chk("single_wrap", 16'(rsp_wrap), 16'h0);
    step();
    set(0, 4'b0100, 0, 0, 16'hFFFF, 0, 1);
    step();
    set(0, 4'b0100, 0, 0, 16'h7FFF, 0, 1);
    mid();
    chk("wrap_data", rsp_data, 16'h0000);
    chk("wrap_flag", 16'(rsp_wrap), 16'h1);
    chk("wrap_id", 16'(rsp_id), 16'h2);
    step();
    set(0, 4'b0000, 0, 0, 0, 0, 1);
    mid();
    chk("nowrap_data", rsp_data, 16'h8000);
    chk("nowrap_flag", 16'(rsp_wrap), 16'h0);
    step();
    set(0, 4'b1000, 0, 0, 0, 16'h0042, 1);
    step();
    set(0, 4'b1111, 16'h0010, 16'h0011, 16'h0012, 16'h0013, 1);
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("rr_grant", 16'(req_ready), 16'(1 << (i % 4)));
      if (i > 0) chk("rr_data", rsp_data, 16'h0011 + 16'((i - 1) % 4));
      chk("rr_valid", 16'(rsp_valid), 16'h1);
      step();
    end
    set(0, 4'b0010, 0, 16'h0100, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("bp_ready", 16'(req_ready), 16'h0);
      chk("bp_data", rsp_data, 16'h0011);
      chk("bp_id", 16'(rsp_id), 16'h0);
      step();
    end
    rsp_ready = 1'b1;
    mid();
    chk("bp_release", 16'(req_ready), 16'h0002);
    step();
    set(0, 4'b0000, 0, 0, 0, 0, 0);
    mid();
    chk("bp_next_valid", 16'(rsp_valid), 16'h1);
    chk("bp_next_data", rsp_data, 16'h0101);
    chk("bp_next_id", 16'(rsp_id), 16'h1);
    step();
    set(1, 4'b0000, 0, 0, 0, 0, 0);
    step();
    set(0, 4'b1001, 16'h0A00, 0, 0, 16'h0B00, 1);
    mid();
    chk("mr_valid", 16'(rsp_valid), 16'h0);
    chk("mr_ptr0", 16'(req_ready), 16'h0001);
    step();
    set(0, 4'b1000, 0, 0, 0, 16'h0B00, 1);
    mid();
    chk("mr_r3", 16'(req_ready), 16'h0008);
    step();
    set(0, 4'b0010, 0, 16'h0C00, 0, 0, 1);
    mid();
    chk("ps_r1", 16'(req_ready), 16'h0002);
    step();
    set(0, 4'b0000, 0, 0, 0, 0, 1);
    repeat (5) step();
    set(0, 4'b1001, 16'h0D00, 0, 0, 16'h0E00, 1);
    mid();
    chk("ps_first", 16'(req_ready), 16'h0008);
    step();
    mid();
    chk("ps_second", 16'(req_ready), 16'h0001);
    chk("ps_data3", rsp_data, 16'h0E01);
    step();
    set(0, 4'b0000, 0, 0, 0, 0, 1);
    mid();
    chk("ps_data0", rsp_data, 16'h0D01);
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/inc16_arbiter.md
Name: inc16_arbiter

Overview:
Shares one 16-bit incrementer (out = in + 1, modulo 2^16) among N requesters. Each requester presents a 16-bit operand with a valid/ready handshake. A round-robin arbiter grants one requester per cycle. The incremented result is returned through a single registered response port with backpressure. It sits between CPU-side clients (PC update, address stepping, counters) and the shared increment datapath.

Parameters:
N, 4, number of requesters; N >= 2.
ID_W, 2, width of the requester index; must equal clog2(N).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
req_valid  input  N  bit i = requester i presents an operand.
req_data  input  16*N  operand of requester i at bits [16*i+15:16*i].
req_ready  output  N  bit i = operand of requester i accepted this cycle (one-hot or zero).
rsp_valid  output  1  response register holds a result.
rsp_data  output  16  incremented operand.
rsp_id  output  ID_W  index of the requester that issued the result.
rsp_wrap  output  1  1 when the operand was 16'hFFFF, so the result wrapped to 16'h0000.
rsp_ready  input  1  consumer accepts the response this cycle.

Behaviour:
- Reset (reset=1 at a clock edge):
  - rsp_valid=0, rsp_data=16'h0000, rsp_id=0, rsp_wrap=0, round-robin pointer rr_ptr=0.
  - While reset=1, req_ready=0 combinationally.
  - A reset asserted mid-transaction discards any held response; no handshake completes in that cycle.
- Two states, encoded by rsp_valid:
  - EMPTY (rsp_valid=0).
  - FULL (rsp_valid=1).
- can_accept = !rsp_valid || rsp_ready.
- Grant (combinational):
  - If can_accept and any req_valid bit is set, g = the first index i with req_valid[i]=1, searching cyclically from rr_ptr (rr_ptr, rr_ptr+1, ..., wrapping mod N).
  - req_ready[g]=1; all other req_ready bits are 0.
  - If no grant is possible, req_ready=0.
  - req_ready never depends on req_data.
- Transfer occurs on a cycle where req_valid[g] & req_ready[g]. At the clock edge:
  - rsp_data <= req_data[g] + 1, truncated to 16 bits.
  - rsp_wrap <= (req_data[g] == 16'hFFFF).
  - rsp_id <= g.
  - rsp_valid <= 1.
  - rr_ptr <= (g + 1) mod N.
- Latency: 1 cycle. The operand accepted at edge k appears on rsp_* after edge k.
- Throughput: 1 result per cycle while rsp_ready=1. A response consumed and a new transfer in the same cycle keeps rsp_valid=1 with the new result (no bubble).
- Response consumed with no transfer: rsp_valid <= 0. rsp_data, rsp_id and rsp_wrap keep their last values.
- Backpressure: while rsp_valid=1 and rsp_ready=0:
  - rsp_data, rsp_id and rsp_wrap are held stable.
  - req_ready=0.
  - rr_ptr is unchanged.
- rr_ptr changes only on a transfer. Idle cycles and stalled cycles do not move it.
- Fairness: with all N requesters continuously valid and rsp_ready=1, grants follow 0,1,...,N-1,0,... No requester waits more than N-1 grants.
- Requesters keep req_data stable while req_valid=1 and not yet accepted. The block samples req_data only on the transfer edge.
- rsp_ready while rsp_valid=0 has no effect.

Test Plan:
- Reset, then single request: assert reset for 2 cycles, then release.
  - During reset, all req_ready=0.
  - After reset, all outputs are 0.
  - req_valid=4'b0001 with data 16'h0005 -> req_ready=4'b0001 that cycle.
  - Next cycle: rsp_valid=1, rsp_data=16'h0006, rsp_id=0, rsp_wrap=0.
- Wrap: requester 2 sends 16'hFFFF -> rsp_data=16'h0000, rsp_wrap=1, rsp_id=2.
  - Then requester 2 sends 16'h7FFF -> rsp_data=16'h8000, rsp_wrap=0.
- Round-robin: all 4 valid with data 16'h0010+i, rsp_ready=1 held -> grants 0,1,2,3,0 on consecutive cycles.
  - rsp_data sequence is 0011, 0012, 0013, 0014, 0011, with no idle cycles.
- Backpressure: rsp_ready=0 for 3 cycles while FULL with requester 1 pending.
  - rsp_data/rsp_id stay constant and req_ready=0 throughout.
  - On the cycle rsp_ready=1, req_ready[1]=1.
  - The next result follows with no bubble.
- Reset mid-operation: FULL, rsp_ready=0, then reset=1 for 1 cycle.
  - rsp_valid=0 and rr_ptr=0 afterwards.
  - Next request from requester 3 alone is still granted; with requesters 0 and 3 both valid, requester 0 is granted first.
- Pointer stability: grant requester 1 (rr_ptr becomes 2), then 5 idle cycles.
  - Requesters 0 and 3 then assert together -> requester 3 is granted first, then requester 0.
